// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART command framer.
// Holds the RX/TX state encodings and counter sizing.
package uart_cmd_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        R_IDLE,
        R_COLLECT
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_LOAD,
        T_ARM,
        T_WAIT
    } tx_state_t;

    // Counter width able to hold 0..n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_resp_ser.sv
// Response serialiser: splits a response word into bytes
// and hands them one at a time to the UART transmitter.
module uart_resp_ser
    import uart_cmd_pkg::*;
#(
    parameter int RESP_BYTES = 2,
    parameter int MSB_FIRST  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         resp_vld,
    input  logic [RESP_BYTES*BYTE_W-1:0] resp_data,
    output logic                         resp_busy,
    output logic                         resp_done,
    output logic                         trmt,
    output logic [BYTE_W-1:0]            tx_data,
    input  logic                         tx_done
);

    localparam int RESP_W = RESP_BYTES * BYTE_W;
    localparam int RW     = cnt_w(RESP_BYTES);
    localparam logic [RW-1:0] LAST = RW'(RESP_BYTES - 1);

    tx_state_t         state_q, state_d;
    logic [RESP_W-1:0] sh_q;
    logic [RESP_W-1:0] src;
    logic [RESP_W-1:0] src_sh;
    logic [BYTE_W-1:0] src_byte;
    logic [RW-1:0]     rem_q;
    logic              cap, nxt, fin;

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        nxt     = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            T_IDLE: begin
                if (resp_vld) begin
                    cap     = 1'b1;
                    state_d = T_LOAD;
                end
            end
            T_LOAD: state_d = T_ARM;
            // tx_done may still be high from the previous byte here
            T_ARM:  state_d = T_WAIT;
            T_WAIT: begin
                if (tx_done) begin
                    if (rem_q != '0) begin
                        nxt     = 1'b1;
                        state_d = T_LOAD;
                    end else begin
                        fin     = 1'b1;
                        state_d = T_IDLE;
                    end
                end
            end
            default: state_d = T_IDLE;
        endcase
    end

    always_comb begin
        src = cap ? resp_data : sh_q;
        if (MSB_FIRST != 0) begin
            src_byte = src[RESP_W-1 -: BYTE_W];
            src_sh   = src << BYTE_W;
        end else begin
            src_byte = src[BYTE_W-1:0];
            src_sh   = src >> BYTE_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= T_IDLE;
            sh_q      <= '0;
            rem_q     <= '0;
            tx_data   <= '0;
            resp_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            resp_done <= fin;
            if (cap || nxt) begin
                tx_data <= src_byte;
                sh_q    <= src_sh;
            end
            if (cap) begin
                rem_q <= LAST;
            end else if (nxt) begin
                rem_q <= rem_q - 1'b1;
            end
        end
    end

    assign resp_busy = (state_q != T_IDLE);
    assign trmt      = (state_q == T_LOAD);

endmodule

// File: rtl/uart_cmd_frame.sv
// Command framer: assembles UART bytes into command words
// with timeout resync and overrun flag; serialises responses.
module uart_cmd_frame
    import uart_cmd_pkg::*;
#(
    parameter int CMD_BYTES      = 3,
    parameter int RESP_BYTES     = 2,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic [BYTE_W-1:0]            rx_data,
    output logic                         clr_rdy,
    output logic [CMD_BYTES*BYTE_W-1:0]  cmd,
    output logic                         cmd_rdy,
    input  logic                         clr_cmd_rdy,
    output logic                         overrun,
    output logic                         frame_err,
    input  logic                         resp_vld,
    input  logic [RESP_BYTES*BYTE_W-1:0] resp_data,
    output logic                         resp_busy,
    output logic                         resp_done,
    output logic                         trmt,
    output logic [BYTE_W-1:0]            tx_data,
    input  logic                         tx_done
);

    localparam int CMD_W = CMD_BYTES * BYTE_W;
    localparam int CW    = cnt_w(CMD_BYTES);
    localparam int TW    = cnt_w(TIMEOUT_CYCLES > 1 ? TIMEOUT_CYCLES : 2);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] LAST    = CW'(CMD_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST =
        TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    to_q, to_d;
    logic [CMD_W-1:0] sh_q, sh_d, word;
    logic             fe_d, done;

    assign clr_rdy = rdy;

    always_comb begin
        if (MSB_FIRST != 0) begin
            word = (sh_q << BYTE_W) | CMD_W'(rx_data);
        end else begin
            word = (sh_q >> BYTE_W)
                 | (CMD_W'(rx_data) << (CMD_W - BYTE_W));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        sh_d    = sh_q;
        fe_d    = 1'b0;
        done    = 1'b0;
        // An incoming byte always beats the timeout
        if (rdy) begin
            to_d = '0;
            if (cnt_q == LAST) begin
                done    = 1'b1;
                cnt_d   = '0;
                sh_d    = '0;
                state_d = R_IDLE;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                sh_d    = word;
                state_d = R_COLLECT;
            end
        end else if (state_q == R_COLLECT) begin
            if (TO_EN && to_q == TO_LAST) begin
                fe_d    = 1'b1;
                cnt_d   = '0;
                to_d    = '0;
                sh_d    = '0;
                state_d = R_IDLE;
            end else if (TO_EN) begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= R_IDLE;
            cnt_q     <= '0;
            to_q      <= '0;
            sh_q      <= '0;
            frame_err <= 1'b0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            sh_q      <= sh_d;
            frame_err <= fe_d;
            if (done) begin
                cmd     <= word;
                cmd_rdy <= 1'b1;
                overrun <= cmd_rdy & ~clr_cmd_rdy;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

    uart_resp_ser #(
        .RESP_BYTES (RESP_BYTES),
        .MSB_FIRST  (MSB_FIRST)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .resp_vld  (resp_vld),
        .resp_data (resp_data),
        .resp_busy (resp_busy),
        .resp_done (resp_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .tx_done   (tx_done)
    );

endmodule

// File: tb/tb_uart_cmd_frame.sv
// Bench for uart_cmd_frame: MSB-first 3/2-byte instance with short
// timeout, LSB-first 4/3-byte instance with timeout disabled.
module tb_uart_cmd_frame;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        a_rdy = 1'b0;
    logic [7:0]  a_rx = '0;
    logic        a_clr_rdy;
    logic [23:0] a_cmd;
    logic        a_cmd_rdy;
    logic        a_clr_cmd = 1'b0;
    logic        a_ovr, a_fe;
    logic        a_vld = 1'b0;
    logic [15:0] a_resp = '0;
    logic        a_busy, a_done, a_trmt;
    logic [7:0]  a_txd;
    logic        a_tx_done = 1'b1;

    logic        b_rdy = 1'b0;
    logic [7:0]  b_rx = '0;
    logic        b_clr_rdy;
    logic [31:0] b_cmd;
    logic        b_cmd_rdy;
    logic        b_clr_cmd = 1'b0;
    logic        b_ovr, b_fe;
    logic        b_vld = 1'b0;
    logic [23:0] b_resp = '0;
    logic        b_busy, b_done, b_trmt;
    logic [7:0]  b_txd;
    logic        b_tx_done = 1'b1;

    uart_cmd_frame #(
        .CMD_BYTES(3), .RESP_BYTES(2),
        .MSB_FIRST(1), .TIMEOUT_CYCLES(64)
    ) u_a (
        .clk(clk), .rst_n(rst_n),
        .rdy(a_rdy), .rx_data(a_rx), .clr_rdy(a_clr_rdy),
        .cmd(a_cmd), .cmd_rdy(a_cmd_rdy),
        .clr_cmd_rdy(a_clr_cmd), .overrun(a_ovr),
        .frame_err(a_fe), .resp_vld(a_vld),
        .resp_data(a_resp), .resp_busy(a_busy),
        .resp_done(a_done), .trmt(a_trmt),
        .tx_data(a_txd), .tx_done(a_tx_done)
    );

    uart_cmd_frame #(
        .CMD_BYTES(4), .RESP_BYTES(3),
        .MSB_FIRST(0), .TIMEOUT_CYCLES(0)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .rdy(b_rdy), .rx_data(b_rx), .clr_rdy(b_clr_rdy),
        .cmd(b_cmd), .cmd_rdy(b_cmd_rdy),
        .clr_cmd_rdy(b_clr_cmd), .overrun(b_ovr),
        .frame_err(b_fe), .resp_vld(b_vld),
        .resp_data(b_resp), .resp_busy(b_busy),
        .resp_done(b_done), .trmt(b_trmt),
        .tx_data(b_txd), .tx_done(b_tx_done)
    );

    // Transmitter models: record each byte, raise tx_done after a delay
    logic [7:0] a_txq[$];
    logic [7:0] b_txq[$];
    logic [7:0] a_hold = '0, b_hold = '0;
    int a_tmr = 0, b_tmr = 0, a_dly = 30, b_dly = 5;
    int a_stab = 0, b_stab = 0;
    int a_done_cnt = 0, b_done_cnt = 0, a_fe_cnt = 0, b_fe_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_tmr <= 0;
            a_tx_done <= 1'b1;
        end else if (a_trmt) begin
            a_txq.push_back(a_txd);
            a_hold <= a_txd;
            a_tx_done <= 1'b0;
            a_tmr <= a_dly;
        end else if (a_tmr > 0) begin
            if (a_txd !== a_hold) a_stab <= a_stab + 1;
            if (a_tmr == 1) a_tx_done <= 1'b1;
            a_tmr <= a_tmr - 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_tmr <= 0;
            b_tx_done <= 1'b1;
        end else if (b_trmt) begin
            b_txq.push_back(b_txd);
            b_hold <= b_txd;
            b_tx_done <= 1'b0;
            b_tmr <= b_dly;
        end else if (b_tmr > 0) begin
            if (b_txd !== b_hold) b_stab <= b_stab + 1;
            if (b_tmr == 1) b_tx_done <= 1'b1;
            b_tmr <= b_tmr - 1;
        end
    end

    always @(posedge clk) begin
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
        if (a_fe) a_fe_cnt++;
        if (b_fe) b_fe_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] bt, input logic clr,
                          input int gap);
        a_rdy = 1'b1;
        a_rx = bt;
        a_clr_cmd = clr;
        #1;
        chk("a_clr_rdy", a_clr_rdy, 1);
        cyc(1);
        a_rdy = 1'b0;
        a_clr_cmd = 1'b0;
        cyc(gap);
    endtask

    task automatic send_b(input logic [7:0] bt, input logic clr,
                          input int gap);
        b_rdy = 1'b1;
        b_rx = bt;
        b_clr_cmd = clr;
        #1;
        chk("b_clr_rdy", b_clr_rdy, 1);
        cyc(1);
        b_rdy = 1'b0;
        b_clr_cmd = 1'b0;
        cyc(gap);
    endtask

    task automatic clr_a();
        a_clr_cmd = 1'b1;
        cyc(1);
        a_clr_cmd = 1'b0;
    endtask

    task automatic clr_b();
        b_clr_cmd = 1'b1;
        cyc(1);
        b_clr_cmd = 1'b0;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_cmd"}, a_cmd, 0);
        chk({tag, "_cmd_rdy"}, a_cmd_rdy, 0);
        chk({tag, "_ovr"}, a_ovr, 0);
        chk({tag, "_fe"}, a_fe, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_done"}, a_done, 0);
        chk({tag, "_trmt"}, a_trmt, 0);
        chk({tag, "_txd"}, a_txd, 0);
        chk({tag, "_clr_rdy"}, a_clr_rdy, 0);
    endtask

    typedef struct {
        logic        clr_first;
        logic [7:0]  b0, b1, b2;
        logic [23:0] cmd;
        logic        rdy;
        logic        ovr;
    } vec_t;

    vec_t tbl[5];

    // LSB-first reference model state for instance B
    logic [7:0]  m_q[$];
    logic [31:0] m_cmd = '0;
    logic        m_rdy = 1'b0, m_ovr = 1'b0;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int fe0, d0, first;
        bit ok;

        tbl[0] = '{1'b0, 8'h55, 8'hAA, 8'hE3, 24'h55AAE3, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'h11, 8'h11, 8'h11, 24'h111111, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h22, 8'h22, 8'h22, 24'h222222, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 8'hDE, 8'hAD, 8'hBE, 24'hDEADBE, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h01, 8'h02, 8'h03, 24'h010203, 1'b1, 1'b1};

        cyc(3);
        chk_a_zero("rst0");
        chk("rst0_b_cmd", b_cmd, 0);
        chk("rst0_b_busy", b_busy, 0);
        rst_n = 1'b1;
        cyc(2);

        foreach (tbl[i]) begin
            if (tbl[i].clr_first) clr_a();
            send_a(tbl[i].b0, 1'b0, 0);
            send_a(tbl[i].b1, 1'b0, 0);
            send_a(tbl[i].b2, 1'b0, 0);
            chk("tbl_cmd", a_cmd, tbl[i].cmd);
            chk("tbl_cmd_rdy", a_cmd_rdy, tbl[i].rdy);
            chk("tbl_ovr", a_ovr, tbl[i].ovr);
        end
        clr_a();
        chk("clr_cmd_rdy", a_cmd_rdy, 0);
        chk("clr_ovr", a_ovr, 0);

        // Partial frame abandoned: exactly one pulse, 64 cycles on
        fe0 = a_fe_cnt;
        first = -1;
        send_a(8'h12, 1'b0, 0);
        send_a(8'h34, 1'b0, 0);
        for (int i = 1; i <= 80; i++) begin
            cyc(1);
            if (a_fe && first < 0) first = i;
        end
        chk("to_when", first, 64);
        chk("to_count", a_fe_cnt - fe0, 1);
        chk("to_cmd_kept", a_cmd, 24'h010203);
        chk("to_rdy_kept", a_cmd_rdy, 0);
        send_a(8'hAB, 1'b0, 0);
        send_a(8'hCD, 1'b0, 0);
        send_a(8'hEF, 1'b0, 0);
        chk("resync_cmd", a_cmd, 24'hABCDEF);
        chk("resync_rdy", a_cmd_rdy, 1);

        // Byte arriving on the last timeout cycle wins
        clr_a();
        fe0 = a_fe_cnt;
        send_a(8'h12, 1'b0, 63);
        send_a(8'h34, 1'b0, 63);
        send_a(8'h56, 1'b0, 0);
        chk("edge_cmd", a_cmd, 24'h123456);
        chk("edge_ovr", a_ovr, 0);
        cyc(100);
        chk("edge_no_fe", a_fe_cnt - fe0, 0);

        // Completion and clear in the same cycle
        send_a(8'h77, 1'b0, 0);
        send_a(8'h77, 1'b0, 0);
        send_a(8'h88, 1'b1, 0);
        chk("same_cmd", a_cmd, 24'h777788);
        chk("same_rdy", a_cmd_rdy, 1);
        chk("same_ovr", a_ovr, 0);
        clr_a();
        chk("same_clr", a_cmd_rdy, 0);

        // Response BEEF with resp_vld held while busy
        a_txq.delete();
        d0 = a_done_cnt;
        a_resp = 16'hBEEF;
        a_vld = 1'b1;
        cyc(1);
        chk("resp_busy", a_busy, 1);
        cyc(20);
        a_vld = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            cyc(1);
            if (a_done) ok = 1'b1;
        end
        chk("resp_done_seen", ok, 1);
        chk("resp_busy_low", a_busy, 0);
        cyc(20);
        chk("resp_nbytes", a_txq.size(), 2);
        if (a_txq.size() == 2) begin
            chk("resp_b0", a_txq[0], 8'hBE);
            chk("resp_b1", a_txq[1], 8'hEF);
        end
        chk("resp_done_cnt", a_done_cnt - d0, 1);
        chk("resp_stable", a_stab, 0);

        // Spec example for the LSB-first 4-byte instance
        send_b(8'h01, 1'b0, 0);
        send_b(8'h02, 1'b0, 0);
        send_b(8'h03, 1'b0, 0);
        send_b(8'h04, 1'b0, 0);
        chk("lsb_cmd", b_cmd, 32'h04030201);
        chk("lsb_rdy", b_cmd_rdy, 1);
        clr_b();

        fork
            begin
                logic [7:0] bt;
                logic       c;
                int         g;
                for (int i = 0; i < 80; i++) begin
                    if ($urandom_range(0, 5) == 0) begin
                        clr_b();
                        m_rdy = 1'b0;
                        m_ovr = 1'b0;
                    end
                    bt = 8'($urandom);
                    c = ($urandom_range(0, 4) == 0);
                    g = ($urandom_range(0, 9) == 0)
                      ? 150 : $urandom_range(0, 3);
                    send_b(bt, c, 0);
                    m_q.push_back(bt);
                    if (m_q.size() == 4) begin
                        m_ovr = m_rdy && !c;
                        m_rdy = 1'b1;
                        m_cmd = {m_q[3], m_q[2], m_q[1], m_q[0]};
                        m_q.delete();
                    end else if (c) begin
                        m_rdy = 1'b0;
                        m_ovr = 1'b0;
                    end
                    chk("rnd_rdy", b_cmd_rdy, m_rdy);
                    chk("rnd_ovr", b_ovr, m_ovr);
                    if (m_rdy) chk("rnd_cmd", b_cmd, m_cmd);
                    cyc(g);
                end
            end
            begin
                logic [23:0] w;
                bit          okb;
                int          db;
                for (int k = 0; k < 6; k++) begin
                    cyc(1);
                    w = 24'($urandom);
                    b_dly = $urandom_range(1, 15);
                    b_txq.delete();
                    db = b_done_cnt;
                    b_resp = w;
                    b_vld = 1'b1;
                    cyc(1);
                    b_vld = 1'b0;
                    okb = 1'b0;
                    for (int t = 0; t < 400 && !okb; t++) begin
                        cyc(1);
                        if (b_done) okb = 1'b1;
                    end
                    chk("rtx_done_seen", okb, 1);
                    chk("rtx_busy_low", b_busy, 0);
                    cyc(1);
                    chk("rtx_nbytes", b_txq.size(), 3);
                    if (b_txq.size() == 3) begin
                        chk("rtx_b0", b_txq[0], w[7:0]);
                        chk("rtx_b1", b_txq[1], w[15:8]);
                        chk("rtx_b2", b_txq[2], w[23:16]);
                    end
                    chk("rtx_done_cnt", b_done_cnt - db, 1);
                end
            end
        join
        chk("rnd_no_fe", b_fe_cnt, 0);
        chk("rnd_stable", b_stab, 0);

        // Reset mid-command and mid-response
        clr_a();
        send_a(8'h12, 1'b0, 0);
        send_a(8'h34, 1'b0, 0);
        a_txq.delete();
        a_resp = 16'h1234;
        a_vld = 1'b1;
        cyc(1);
        a_vld = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            cyc(1);
            if (a_txq.size() >= 1) ok = 1'b1;
        end
        chk("rst_tx_started", ok, 1);
        cyc(5);
        rst_n = 1'b0;
        #2;
        chk_a_zero("rst1");
        cyc(2);
        rst_n = 1'b1;
        a_txq.delete();
        cyc(100);
        chk("rst_no_tx", a_txq.size(), 0);
        chk("rst_busy", a_busy, 0);
        send_a(8'hC0, 1'b0, 0);
        send_a(8'hFF, 1'b0, 0);
        send_a(8'hEE, 1'b0, 0);
        chk("rst_cmd", a_cmd, 24'hC0FFEE);
        chk("rst_rdy", a_cmd_rdy, 1);
        chk("rst_ovr", a_ovr, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
